// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//   Shared definitions for the FFT operand feeder slice:
//   - default WORD_SIZE / N_POINTS values
//   - addr_w(): index width for a frame of n samples
//   - state_t : feeder FSM states (FILL, ISSUE)
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int WORD_SIZE_DEF = 16;
  localparam int N_POINTS_DEF  = 16;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// ---------------------------------------------------------------------------
// fft_frame_ram
//   Frame buffer for the triplet feeder: one synchronous write port and three
//   asynchronous read ports (one per adder operand). BANKS selects one or two
//   frame banks; with BANKS=1 the bank selects are ignored.
// Ports
//   i_clk        clock, rising edge
//   i_we         write enable
//   i_wr_bank    bank written (BANKS=2 only)
//   i_wr_addr    sample index written
//   i_wr_data    sample written
//   i_rd_bank    bank read by all three read ports (BANKS=2 only)
//   i_rd_addr_a/b/c  sample index per read port
//   o_rd_a/b/c   read data per read port
// ---------------------------------------------------------------------------
module fft_frame_ram
  import fft_pkg::*;
#(
  parameter int  WORD_SIZE = WORD_SIZE_DEF,
  parameter int  N_POINTS  = N_POINTS_DEF,
  parameter int  BANKS     = 1,
  localparam int ADDR_W    = addr_w(N_POINTS)
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic                 i_wr_bank,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [WORD_SIZE-1:0] i_wr_data,
  input  logic                 i_rd_bank,
  input  logic [ADDR_W-1:0]    i_rd_addr_a,
  input  logic [ADDR_W-1:0]    i_rd_addr_b,
  input  logic [ADDR_W-1:0]    i_rd_addr_c,
  output logic [WORD_SIZE-1:0] o_rd_a,
  output logic [WORD_SIZE-1:0] o_rd_b,
  output logic [WORD_SIZE-1:0] o_rd_c
);

  // Storage is always sized for two banks; with BANKS=1 the upper bank is
  // never addressed and is trimmed away.
  logic [WORD_SIZE-1:0] r_mem [0:2*N_POINTS-1];
  logic                 w_wr_bank;
  logic                 w_rd_bank;

  assign w_wr_bank = (BANKS > 1) ? i_wr_bank : 1'b0;
  assign w_rd_bank = (BANKS > 1) ? i_rd_bank : 1'b0;

  // Sample write port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[{w_wr_bank, i_wr_addr}] <= i_wr_data;
    end
  end

  assign o_rd_a = r_mem[{w_rd_bank, i_rd_addr_a}];
  assign o_rd_b = r_mem[{w_rd_bank, i_rd_addr_b}];
  assign o_rd_c = r_mem[{w_rd_bank, i_rd_addr_c}];

endmodule

// File: rtl/fft_triplet_feeder.sv
// ---------------------------------------------------------------------------
// fft_triplet_feeder
//   Operand stage for the 3-input adder of the 16-point FFT datapath.
//   Collects a frame of N_POINTS samples from a valid/ready stream, then
//   issues one triplet per cycle: A=x[k], B=x[(k+1)%N], C=x[(k+2)%N],
//   k=0..N-1, with o_sum_valid/o_sum_index delayed ADDER_LAT cycles to line
//   up with the adder's registered sum.
// Configuration
//   PINGPONG_EN  defined: two frame banks, filling one while issuing the
//                other (gapless issue under a continuous input stream).
//                undefined: single bank, o_ready low for the whole issue.
// Ports
//   i_clk, i_rst           clock; synchronous active-high reset
//   i_data, i_valid        input sample stream
//   o_ready                sample accepted when i_valid && o_ready
//   o_A, o_B, o_C          operand triplet for the adder
//   o_valid, o_index       triplet valid and its index k
//   o_last                 o_valid && k == N_POINTS-1
//   o_sum_valid/o_sum_index  o_valid/o_index delayed ADDER_LAT cycles
// ---------------------------------------------------------------------------
module fft_triplet_feeder
  import fft_pkg::*;
#(
  parameter int  WORD_SIZE = WORD_SIZE_DEF,
  parameter int  N_POINTS  = N_POINTS_DEF,
  parameter int  ADDER_LAT = 1,
  localparam int ADDR_W    = addr_w(N_POINTS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [WORD_SIZE-1:0] o_A,
  output logic [WORD_SIZE-1:0] o_B,
  output logic [WORD_SIZE-1:0] o_C,
  output logic                 o_valid,
  output logic [ADDR_W-1:0]    o_index,
  output logic                 o_last,
  output logic                 o_sum_valid,
  output logic [ADDR_W-1:0]    o_sum_index
);

`ifdef PINGPONG_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(N_POINTS - 1);

  state_t                r_state;
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic                  r_sv_pipe [ADDER_LAT];
  logic [ADDR_W-1:0]     r_si_pipe [ADDER_LAT];

`ifdef PINGPONG_EN
  logic                  r_fill_bank;   // bank currently being written
  logic                  r_issue_bank;  // bank currently being issued
  logic                  r_pend;        // a full bank is waiting for issue to end
  logic                  w_pend_next;
`endif

  logic                  w_accept;
  logic                  w_fill_done;
  logic                  w_issue_end;
  logic                  w_start;
  logic                  w_cont;
  logic                  w_next_valid;
  logic                  w_wr_bank;
  logic                  w_rd_bank;
  logic [ADDR_W-1:0]     w_rd_k;
  logic [WORD_SIZE-1:0]  w_a;
  logic [WORD_SIZE-1:0]  w_b;
  logic [WORD_SIZE-1:0]  w_c;

  assign w_accept    = i_valid & o_ready;
  assign w_fill_done = w_accept & (r_wr_ptr == LAST_K);
  assign w_issue_end = o_valid & o_last;

`ifdef PINGPONG_EN
  assign w_wr_bank = r_fill_bank;
`else
  assign w_wr_bank = 1'b0;
`endif

  // Decide what the next cycle presents: a new frame from k=0, the next k
  // of the running frame, or nothing.
  always_comb begin
    w_start   = 1'b0;
    w_rd_bank = 1'b0;
    w_rd_k    = {ADDR_W{1'b0}};
    w_cont    = (r_state == ST_ISSUE) & ~w_issue_end;
`ifdef PINGPONG_EN
    // A new frame starts when a bank completes while idle, or when the
    // running frame ends with a full bank ready (completed now or earlier).
    w_start = ((r_state == ST_FILL) & w_fill_done) |
              (w_issue_end & (w_fill_done | r_pend));
    if (w_start) begin
      if (r_pend) begin
        w_rd_bank = ~r_issue_bank;
      end else begin
        w_rd_bank = r_fill_bank;
      end
    end else begin
      w_rd_bank = r_issue_bank;
    end
    if (r_pend) begin
      w_pend_next = ~w_issue_end;
    end else begin
      w_pend_next = w_fill_done & (r_state == ST_ISSUE) & ~w_issue_end;
    end
`else
    w_start   = (r_state == ST_FILL) & w_fill_done;
    w_rd_bank = 1'b0;
`endif
    if (w_start) begin
      w_rd_k = {ADDR_W{1'b0}};
    end else begin
      w_rd_k = o_index + ADDR_W'(1);
    end
    w_next_valid = w_start | w_cont;
  end

  fft_frame_ram #(
    .WORD_SIZE (WORD_SIZE),
    .N_POINTS  (N_POINTS),
    .BANKS     (BANKS)
  ) u_ram (
    .i_clk       (i_clk),
    .i_we        (w_accept),
    .i_wr_bank   (w_wr_bank),
    .i_wr_addr   (r_wr_ptr),
    .i_wr_data   (i_data),
    .i_rd_bank   (w_rd_bank),
    .i_rd_addr_a (w_rd_k),
    .i_rd_addr_b (w_rd_k + ADDR_W'(1)),  // ADDR_W-bit wrap gives modulo N
    .i_rd_addr_c (w_rd_k + ADDR_W'(2)),
    .o_rd_a      (w_a),
    .o_rd_b      (w_b),
    .o_rd_c      (w_c)
  );

  // Feeder FSM: write pointer, bank bookkeeping and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_FILL;
      r_wr_ptr <= {ADDR_W{1'b0}};
      o_ready  <= 1'b0;
      o_valid  <= 1'b0;
      o_index  <= {ADDR_W{1'b0}};
      o_last   <= 1'b0;
      o_A      <= {WORD_SIZE{1'b0}};
      o_B      <= {WORD_SIZE{1'b0}};
      o_C      <= {WORD_SIZE{1'b0}};
`ifdef PINGPONG_EN
      r_fill_bank  <= 1'b0;
      r_issue_bank <= 1'b0;
      r_pend       <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      r_state <= w_next_valid ? ST_ISSUE : ST_FILL;
      o_valid <= w_next_valid;
      if (w_next_valid) begin
        o_index <= w_rd_k;
        o_last  <= (w_rd_k == LAST_K);
        o_A     <= w_a;
        o_B     <= w_b;
        o_C     <= w_c;
      end else begin
        o_index <= {ADDR_W{1'b0}};
        o_last  <= 1'b0;
        o_A     <= {WORD_SIZE{1'b0}};
        o_B     <= {WORD_SIZE{1'b0}};
        o_C     <= {WORD_SIZE{1'b0}};
      end
`ifdef PINGPONG_EN
      if (w_fill_done) begin
        r_fill_bank <= ~r_fill_bank;
      end
      if (w_start) begin
        r_issue_bank <= w_rd_bank;
      end
      r_pend  <= w_pend_next;
      o_ready <= ~w_pend_next;
`else
      case (r_state)
        ST_FILL:  o_ready <= ~w_fill_done;
        ST_ISSUE: o_ready <= w_issue_end;
        default:  o_ready <= 1'b0;
      endcase
`endif
    end
  end

  // Latency shift of o_valid/o_index to match the adder's registered sum.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ADDER_LAT; i++) begin
        r_sv_pipe[i] <= 1'b0;
        r_si_pipe[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      r_sv_pipe[0] <= o_valid;
      r_si_pipe[0] <= o_index;
      for (int i = 1; i < ADDER_LAT; i++) begin
        r_sv_pipe[i] <= r_sv_pipe[i-1];
        r_si_pipe[i] <= r_si_pipe[i-1];
      end
    end
  end

  assign o_sum_valid = r_sv_pipe[ADDER_LAT-1];
  assign o_sum_index = r_si_pipe[ADDER_LAT-1];

endmodule

// File: tb/tb_fft_triplet_feeder.sv
// ---------------------------------------------------------------------------
// tb_fft_triplet_feeder
//   Scoreboard bench for fft_triplet_feeder. Stimulus pushes expected
//   triplets and adder sums into queues; a negedge monitor pops and compares
//   whenever o_valid / o_sum_valid are high. A behavioural 1-cycle adder
//   stands in for adder3. Pingpong scenario runs when PINGPONG_EN is defined.
// ---------------------------------------------------------------------------
module tb_fft_triplet_feeder;

  localparam int W  = 16;
  localparam int N  = 16;
  localparam int AW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [W-1:0]  i_data;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  o_A, o_B, o_C;
  logic          o_valid;
  logic [AW-1:0] o_index;
  logic          o_last;
  logic          o_sum_valid;
  logic [AW-1:0] o_sum_index;

  fft_triplet_feeder #(.WORD_SIZE(W), .N_POINTS(N), .ADDER_LAT(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_A(o_A), .o_B(o_B), .o_C(o_C),
    .o_valid(o_valid), .o_index(o_index), .o_last(o_last),
    .o_sum_valid(o_sum_valid), .o_sum_index(o_sum_index)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  c;
    logic [AW-1:0] k;
    logic          last;
  } trip_t;

  typedef struct packed {
    logic [W-1:0]  s;
    logic [AW-1:0] k;
  } sum_t;

  trip_t        trip_q[$];
  sum_t         sum_q[$];
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] frame   [N];
  logic [W-1:0] obs_sum [N];
  logic [W-1:0] model_sum;
  bit           ready_watch = 1'b0;
  bit           pp_watch    = 1'b0;

  // Hand-computed adder sums for the frame 0..15.
  logic [W-1:0] hand_sum [N] = '{16'd3, 16'd6, 16'd9, 16'd12, 16'd15, 16'd18,
                                 16'd21, 16'd24, 16'd27, 16'd30, 16'd33, 16'd36,
                                 16'd39, 16'd42, 16'd29, 16'd16};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural stand-in for the registered 3-input adder.
  always @(posedge i_clk) model_sum <= o_A + o_B + o_C;

  // Monitor: pops the scoreboard whenever the DUT presents a triplet or sum.
  initial begin
    forever begin
      trip_t e;
      sum_t  s;
      @(negedge i_clk);
      if (o_valid) begin
        if (trip_q.size() == 0) begin
          check("unexpected_valid", 32'(o_valid), 32'(0));
        end else begin
          e = trip_q.pop_front();
          check("trip_A", 32'(o_A), 32'(e.a));
          check("trip_B", 32'(o_B), 32'(e.b));
          check("trip_C", 32'(o_C), 32'(e.c));
          check("trip_index", 32'(o_index), 32'(e.k));
          check("trip_last", 32'(o_last), 32'(e.last));
        end
        if (ready_watch) check("ready_low_in_issue", 32'(o_ready), 32'(0));
      end
      if (pp_watch) check("pp_ready_high", 32'(o_ready), 32'(1));
      if (o_sum_valid) begin
        obs_sum[o_sum_index] = model_sum;
        if (sum_q.size() == 0) begin
          check("unexpected_sum_valid", 32'(o_sum_valid), 32'(0));
        end else begin
          s = sum_q.pop_front();
          check("sum_value", 32'(model_sum), 32'(s.s));
          check("sum_index", 32'(o_sum_index), 32'(s.k));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(o_ready), 32'(0));
    check({tag, "_valid"}, 32'(o_valid), 32'(0));
    check({tag, "_A"}, 32'(o_A), 32'(0));
    check({tag, "_B"}, 32'(o_B), 32'(0));
    check({tag, "_C"}, 32'(o_C), 32'(0));
    check({tag, "_index"}, 32'(o_index), 32'(0));
    check({tag, "_last"}, 32'(o_last), 32'(0));
    check({tag, "_sum_valid"}, 32'(o_sum_valid), 32'(0));
    check({tag, "_sum_index"}, 32'(o_sum_index), 32'(0));
  endtask

  task automatic do_reset();
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = 16'h0000;
    repeat (2) @(posedge i_clk);
    #1;
    check_all_zero("reset");
    i_rst = 1'b0;
  endtask

  // Offer frame[lo..hi]; optionally idle i_valid every other cycle.
  task automatic send_samples(input int lo, input int hi, input bit toggle);
    int idx    = lo;
    int budget = 0;
    bit gap    = 1'b0;
    bit rdy;
    while (idx <= hi && budget < 400) begin
      if (toggle && gap) begin
        i_valid = 1'b0;
      end else begin
        i_valid = 1'b1;
        i_data  = frame[idx];
      end
      rdy = o_ready;
      @(posedge i_clk);
      #1;
      if (i_valid && rdy) idx++;
      if (toggle) gap = ~gap;
      budget++;
    end
    i_valid = 1'b0;
    if (idx <= hi) check("accept_timeout", 32'(idx), 32'(hi + 1));
  endtask

  task automatic push_expected();
    for (int k = 0; k < N; k++) begin
      trip_t t;
      sum_t  s;
      t.a    = frame[k];
      t.b    = frame[(k + 1) % N];
      t.c    = frame[(k + 2) % N];
      t.k    = AW'(k);
      t.last = (k == N - 1);
      s.s    = frame[k] + frame[(k + 1) % N] + frame[(k + 2) % N];
      s.k    = AW'(k);
      trip_q.push_back(t);
      sum_q.push_back(s);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((trip_q.size() != 0 || sum_q.size() != 0) && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    check("drain_timeout", 32'(trip_q.size() + sum_q.size()), 32'(0));
    @(negedge i_clk);
  endtask

  initial begin
    int n;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = 16'h0000;
`ifndef PINGPONG_EN
    ready_watch = 1'b1;
`endif

    // Reset, frame 0..15, adder sums
    do_reset();
    for (int i = 0; i < N; i++) frame[i] = W'(i);
    send_samples(0, N - 1, 1'b0);
    push_expected();
    wait_drain();
    for (int k = 0; k < N; k++) check("hand_sum", 32'(obs_sum[k]), 32'(hand_sum[k]));

    // Toggled i_valid, frame 0x8000..0x800F
    for (int i = 0; i < N; i++) frame[i] = 16'h8000 + W'(i);
    send_samples(0, N - 1, 1'b1);
    push_expected();
    wait_drain();

    // Reset at k=7 mid-issue, then frame of 0xFFFF
    for (int i = 0; i < N; i++) frame[i] = 16'h0040 + W'(i);
    send_samples(0, N - 1, 1'b0);
    push_expected();
    n = 0;
    while (!(o_valid && o_index == 4'd7) && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    check("reach_k7", 32'(o_index), 32'(7));
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    check_all_zero("abort");
    trip_q.delete();
    sum_q.delete();
    @(posedge i_clk);
    #1;
    check_all_zero("abort_hold");
    i_rst = 1'b0;
    for (int i = 0; i < N; i++) frame[i] = 16'hFFFF;
    send_samples(0, N - 1, 1'b0);
    push_expected();
    wait_drain();
    check("ffff_sum_k0", 32'(obs_sum[0]), 32'(16'hFFFD));
    check("ffff_sum_k15", 32'(obs_sum[15]), 32'(16'hFFFD));

    // Partial frame, 50-cycle stall, then the rest
    for (int i = 0; i < N; i++) frame[i] = 16'h0100 + W'(i * 3);
    send_samples(0, 9, 1'b0);
    repeat (50) begin
      @(negedge i_clk);
      check("stall_no_valid", 32'(o_valid), 32'(0));
      check("stall_ready", 32'(o_ready), 32'(1));
    end
    send_samples(10, N - 1, 1'b0);
    push_expected();
    wait_drain();

`ifdef PINGPONG_EN
    // Three back-to-back frames: gapless issue, o_ready never drops
    do_reset();
    @(posedge i_clk);
    #1;
    pp_watch = 1'b1;
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          for (int i = 0; i < N; i++) frame[i] = W'(16 * f + i);
          send_samples(0, N - 1, 1'b0);
          push_expected();
        end
      end
      begin
        int m = 0;
        while (!o_valid && m < 100) begin
          @(negedge i_clk);
          m++;
        end
        check("pp_first_valid", 32'(o_valid), 32'(1));
        repeat (3 * N - 1) begin
          @(negedge i_clk);
          check("pp_gapless", 32'(o_valid), 32'(1));
        end
      end
    join
    wait_drain();
    pp_watch = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
